// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel integer clock divider with a settle/lock indicator.
// Every channel runs off refclk and produces a registered divided clock plus a
// one-cycle tick on each rising edge of that clock.
// Build option: define CLK_DIV_GEN_CFG_EN to compile in the runtime divisor
// update handshake (cfg_valid/cfg_ready). Without it, the divisors are fixed at
// their parameter values and cfg_ready is held low.
module clk_div_gen #(
  parameter int unsigned NUM_CLKS    = 2,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DIV0        = 2,
  parameter int unsigned DIV1        = 434,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_sel,
  input  logic [DIV_W-1:0]    cfg_div,
  output logic [NUM_CLKS-1:0] outclk,
  output logic [NUM_CLKS-1:0] tick,
  output logic                locked
);

  localparam int unsigned LockW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int unsigned HalfW = DIV_W + 1;
  localparam logic [LockW-1:0] LockLast = LockW'(LOCK_CYCLES - 1);

  // A programmed divisor of zero behaves as a divide-by-one.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  // Divisor a channel starts with out of reset.
  function automatic logic [DIV_W-1:0] param_div(input int unsigned ch);
    logic [DIV_W-1:0] d;
    case (ch)
      0:       d = DIV_W'(DIV0);
      1:       d = DIV_W'(DIV1);
      default: d = DIV_W'(1);
    endcase
    return d;
  endfunction

  logic [DIV_W-1:0]    div_cur [NUM_CLKS];
  logic [DIV_W-1:0]    eff     [NUM_CLKS];
  logic [HalfW-1:0]    half    [NUM_CLKS];
  logic [DIV_W-1:0]    cnt_q   [NUM_CLKS];
  logic [DIV_W-1:0]    cnt_d   [NUM_CLKS];
  logic [NUM_CLKS-1:0] wrap;
  logic [NUM_CLKS-1:0] outclk_q, outclk_d;
  logic [NUM_CLKS-1:0] tick_q, tick_d;

  // Per-channel counter: wrap at D-1, high phase covers the first ceil(D/2) counts.
  always_comb begin
    for (int unsigned ch = 0; ch < NUM_CLKS; ch++) begin
      eff[ch]      = eff_div(div_cur[ch]);
      half[ch]     = ({1'b0, eff[ch]} + HalfW'(1)) >> 1;
      wrap[ch]     = (cnt_q[ch] == eff[ch] - DIV_W'(1));
      cnt_d[ch]    = wrap[ch] ? '0 : cnt_q[ch] + DIV_W'(1);
      outclk_d[ch] = ({1'b0, cnt_d[ch]} < half[ch]);
      tick_d[ch]   = wrap[ch];
    end
  end

  // Counters start at D-1 so that every channel wraps on the first edge after reset.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      for (int unsigned ch = 0; ch < NUM_CLKS; ch++) begin
        cnt_q[ch] <= eff_div(param_div(ch)) - DIV_W'(1);
      end
      outclk_q <= '0;
      tick_q   <= '0;
    end else begin
      for (int unsigned ch = 0; ch < NUM_CLKS; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
      outclk_q <= outclk_d;
      tick_q   <= tick_d;
    end
  end

  assign outclk = outclk_q;
  assign tick   = tick_q;

`ifdef CLK_DIV_GEN_CFG_EN
  logic [DIV_W-1:0]    div_q  [NUM_CLKS];
  logic [DIV_W-1:0]    div_d  [NUM_CLKS];
  logic [DIV_W-1:0]    pend_q [NUM_CLKS];
  logic [DIV_W-1:0]    pend_d [NUM_CLKS];
  logic [NUM_CLKS-1:0] pend_vld_q, pend_vld_d;
  logic                sel_ok;
  logic                cfg_hit;
  logic                commit;

  // Requests to a channel that does not exist are swallowed without effect.
  assign sel_ok    = (32'(cfg_sel) < NUM_CLKS);
  assign cfg_ready = ~|pend_vld_q;
  assign cfg_hit   = cfg_valid && cfg_ready && sel_ok;
  assign commit    = |(wrap & pend_vld_q);

  // Active divisor comes from the committed register.
  always_comb begin
    for (int unsigned ch = 0; ch < NUM_CLKS; ch++) begin
      div_cur[ch] = div_q[ch];
    end
  end

  // Pending divisor only becomes active on a wrap; a request landing on a wrap
  // is not yet visible in pend_vld_q, so it waits for the following wrap.
  always_comb begin
    pend_vld_d = pend_vld_q;
    for (int unsigned ch = 0; ch < NUM_CLKS; ch++) begin
      div_d[ch]  = div_q[ch];
      pend_d[ch] = pend_q[ch];
      if (wrap[ch] && pend_vld_q[ch]) begin
        div_d[ch]      = pend_q[ch];
        pend_vld_d[ch] = 1'b0;
      end
      if (cfg_hit && (32'(cfg_sel) == ch)) begin
        pend_d[ch]     = cfg_div;
        pend_vld_d[ch] = 1'b1;
      end
    end
  end

  // Committed and pending divisor registers; reset drops any pending update.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      for (int unsigned ch = 0; ch < NUM_CLKS; ch++) begin
        div_q[ch]  <= param_div(ch);
        pend_q[ch] <= '0;
      end
      pend_vld_q <= '0;
    end else begin
      for (int unsigned ch = 0; ch < NUM_CLKS; ch++) begin
        div_q[ch]  <= div_d[ch];
        pend_q[ch] <= pend_d[ch];
      end
      pend_vld_q <= pend_vld_d;
    end
  end

  typedef enum logic [1:0] {StSettle, StLocked, StPending} lock_state_e;
`else
  logic unused_cfg;

  assign cfg_ready  = 1'b0;
  assign unused_cfg = ^{cfg_valid, cfg_sel, cfg_div};

  // Divisors are fixed at their reset values.
  always_comb begin
    for (int unsigned ch = 0; ch < NUM_CLKS; ch++) begin
      div_cur[ch] = param_div(ch);
    end
  end

  typedef enum logic [0:0] {StSettle, StLocked} lock_state_e;
`endif

  lock_state_e      state_q, state_d;
  logic [LockW-1:0] lock_cnt_q, lock_cnt_d;

  // Lock tracker: count settle cycles, drop lock while an update is outstanding.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      StSettle: begin
`ifdef CLK_DIV_GEN_CFG_EN
        if (cfg_hit) begin
          state_d = StPending;
        end else
`endif
        if (lock_cnt_q == LockLast) begin
          state_d = StLocked;
        end else begin
          lock_cnt_d = lock_cnt_q + LockW'(1);
        end
      end
      StLocked: begin
`ifdef CLK_DIV_GEN_CFG_EN
        if (cfg_hit) begin
          state_d = StPending;
        end
`endif
      end
`ifdef CLK_DIV_GEN_CFG_EN
      StPending: begin
        if (commit) begin
          state_d    = StSettle;
          lock_cnt_d = '0;
        end
      end
`endif
      default: begin
        state_d    = StSettle;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Lock state register.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q    <= StSettle;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign locked = (state_q == StLocked);

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen at default parameters; exercises the update path when
// CLK_DIV_GEN_CFG_EN is defined.
`timescale 1ns/1ps
module tb_clk_div_gen;
  localparam int NC   = 2;
  localparam int W    = 16;
  localparam int LOCK = 16;
`ifdef CLK_DIV_GEN_CFG_EN
  localparam bit CfgOn = 1'b1;
`else
  localparam bit CfgOn = 1'b0;
`endif

  logic          refclk;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_sel;
  logic [W-1:0]  cfg_div;
  logic [NC-1:0] outclk;
  logic [NC-1:0] tick;
  logic          locked;

  int errors;
  int checks;

  clk_div_gen dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_sel  (cfg_sel),
    .cfg_div  (cfg_div),
    .outclk   (outclk),
    .tick     (tick),
    .locked   (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Reference model: each channel is described by the edge at which its current
  // divisor took effect, so phase = (edge - start) mod D.
  int edge_n;
  int settle_start;
  int seg_start [NC];
  int seg_div   [NC];
  int pend_div  [NC];
  bit pend_v    [NC];
  logic [NC-1:0] exp_out, exp_tick;
  logic          exp_locked, exp_ready;

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    edge_n       = 0;
    settle_start = 0;
    for (int ch = 0; ch < NC; ch++) begin
      seg_start[ch] = 1;
      pend_v[ch]    = 1'b0;
      pend_div[ch]  = 1;
    end
    seg_div[0] = 2;
    seg_div[1] = 434;
    exp_out    = '0;
    exp_tick   = '0;
    exp_locked = 1'b0;
    exp_ready  = CfgOn;
  endtask

  // Advance one refclk edge and update the model; returns #1 after the edge.
  task automatic step();
    bit acc;
    bit any;
    int s, d, pos;
    acc = CfgOn && (cfg_valid === 1'b1) && exp_ready;
    s   = int'(cfg_sel);
    d   = eff(int'(cfg_div));
    @(posedge refclk);
    edge_n++;
    for (int ch = 0; ch < NC; ch++) begin
      if (pend_v[ch] && ((edge_n - seg_start[ch]) % seg_div[ch]) == 0) begin
        seg_start[ch] = edge_n;
        seg_div[ch]   = pend_div[ch];
        pend_v[ch]    = 1'b0;
        settle_start  = edge_n;
      end
    end
    if (acc && s < NC) begin
      pend_v[s]   = 1'b1;
      pend_div[s] = d;
    end
    any = 1'b0;
    for (int ch = 0; ch < NC; ch++) begin
      pos          = (edge_n - seg_start[ch]) % seg_div[ch];
      exp_out[ch]  = (pos < (seg_div[ch] + 1) / 2);
      exp_tick[ch] = (pos == 0);
      any          = any | pend_v[ch];
    end
    exp_locked = !any && ((edge_n - settle_start) >= LOCK);
    exp_ready  = CfgOn && !any;
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_sel   = '0;
    cfg_div   = '0;
    model_reset();
    repeat (3) @(posedge refclk);
    #1;
    checks++;
    if ({outclk, tick, locked} !== '0 || cfg_ready !== CfgOn) begin
      errors++;
      $display("FAIL reset_values: got out=%b tick=%b lock=%b rdy=%b expected zeros rdy=%b",
               outclk, tick, locked, cfg_ready, CfgOn);
    end
    @(negedge refclk);
    rst = 1'b1;
    step();
    checks++;
    if ({outclk, tick} !== 4'b1111) begin
      errors++;
      $display("FAIL first_edge: got out=%b tick=%b expected 11 11", outclk, tick);
    end
  endtask

  task automatic test_lock();
    for (int i = 2; i <= 16; i++) begin
      step();
      checks++;
      if ({outclk, tick, locked, cfg_ready} !== {exp_out, exp_tick, exp_locked, exp_ready}) begin
        errors++;
        $display("FAIL lock_run edge %0d: got %b expected %b", edge_n,
                 {outclk, tick, locked, cfg_ready}, {exp_out, exp_tick, exp_locked, exp_ready});
      end
      if (i == 15) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++;
          $display("FAIL lock_early: got %b expected 0", locked);
        end
      end
      if (i == 16) begin
        checks++;
        if (locked !== 1'b1) begin
          errors++;
          $display("FAIL lock_at_16: got %b expected 1", locked);
        end
      end
    end
  endtask

  task automatic test_default_run();
    int t0, t1;
    t0 = 0;
    t1 = 0;
    for (int i = 17; i <= 900; i++) begin
      cfg_valid = CfgOn ? 1'b0 : 1'($urandom_range(0, 1));
      cfg_sel   = 2'($urandom_range(0, 3));
      cfg_div   = W'($urandom);
      step();
      t0 += int'(tick[0]);
      t1 += int'(tick[1]);
      checks++;
      if ({outclk, tick, locked, cfg_ready} !== {exp_out, exp_tick, exp_locked, exp_ready}) begin
        errors++;
        $display("FAIL default_run edge %0d: got %b expected %b", edge_n,
                 {outclk, tick, locked, cfg_ready}, {exp_out, exp_tick, exp_locked, exp_ready});
      end
    end
    cfg_valid = 1'b0;
    checks++;
    if (t0 !== 442) begin
      errors++;
      $display("FAIL tick0_count: got %0d expected 442", t0);
    end
    checks++;
    if (t1 !== 2) begin
      errors++;
      $display("FAIL tick1_count: got %0d expected 2", t1);
    end
  endtask

  task automatic test_async_reset();
    step();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({outclk, tick, locked} !== '0 || cfg_ready !== CfgOn) begin
      errors++;
      $display("FAIL async_reset: got out=%b tick=%b lock=%b rdy=%b expected zeros rdy=%b",
               outclk, tick, locked, cfg_ready, CfgOn);
    end
    @(posedge refclk);
    #1;
    checks++;
    if ({outclk, tick, locked} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got %b expected 0", {outclk, tick, locked});
    end
    @(negedge refclk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 870; i++) begin
      step();
      checks++;
      if ({outclk, tick, locked, cfg_ready} !== {exp_out, exp_tick, exp_locked, exp_ready}) begin
        errors++;
        $display("FAIL after_reset edge %0d: got %b expected %b", edge_n,
                 {outclk, tick, locked, cfg_ready}, {exp_out, exp_tick, exp_locked, exp_ready});
      end
    end
  endtask

`ifdef CLK_DIV_GEN_CFG_EN
  task automatic test_cfg_ch0();
    cfg_valid = 1'b1;
    cfg_sel   = 2'd0;
    cfg_div   = W'(5);
    step();
    cfg_valid = 1'b0;
    checks++;
    if (locked !== 1'b0 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL cfg_ch0_ack: got lock=%b rdy=%b expected 0 0", locked, cfg_ready);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if ({outclk, tick, locked, cfg_ready} !== {exp_out, exp_tick, exp_locked, exp_ready}) begin
        errors++;
        $display("FAIL cfg_ch0 edge %0d: got %b expected %b", edge_n,
                 {outclk, tick, locked, cfg_ready}, {exp_out, exp_tick, exp_locked, exp_ready});
      end
    end
    checks++;
    if (locked !== 1'b1 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_ch0_relock: got lock=%b rdy=%b expected 1 1", locked, cfg_ready);
    end
  endtask

  task automatic test_cfg_zero_ch1();
    cfg_valid = 1'b1;
    cfg_sel   = 2'd1;
    cfg_div   = '0;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 460; i++) begin
      step();
      checks++;
      if ({outclk, tick, locked, cfg_ready} !== {exp_out, exp_tick, exp_locked, exp_ready}) begin
        errors++;
        $display("FAIL cfg_zero edge %0d: got %b expected %b", edge_n,
                 {outclk, tick, locked, cfg_ready}, {exp_out, exp_tick, exp_locked, exp_ready});
      end
    end
    checks++;
    if (outclk[1] !== 1'b1 || tick[1] !== 1'b1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL cfg_zero_final: got out1=%b tick1=%b lock=%b expected 1 1 1",
               outclk[1], tick[1], locked);
    end
  endtask

  task automatic test_cfg_invalid();
    cfg_valid = 1'b1;
    cfg_sel   = 2'd3;
    cfg_div   = W'(9);
    step();
    cfg_valid = 1'b0;
    checks++;
    if (locked !== 1'b1 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_invalid: got lock=%b rdy=%b expected 1 1", locked, cfg_ready);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({outclk, tick, locked, cfg_ready} !== {exp_out, exp_tick, exp_locked, exp_ready}) begin
        errors++;
        $display("FAIL cfg_invalid edge %0d: got %b expected %b", edge_n,
                 {outclk, tick, locked, cfg_ready}, {exp_out, exp_tick, exp_locked, exp_ready});
      end
    end
  endtask

  task automatic test_cfg_random();
    for (int i = 0; i < 600; i++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_sel   = 2'($urandom_range(0, 3));
      cfg_div   = W'($urandom_range(0, 9));
      step();
      checks++;
      if ({outclk, tick, locked, cfg_ready} !== {exp_out, exp_tick, exp_locked, exp_ready}) begin
        errors++;
        $display("FAIL cfg_random edge %0d: got %b expected %b", edge_n,
                 {outclk, tick, locked, cfg_ready}, {exp_out, exp_tick, exp_locked, exp_ready});
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset_pending();
    #2;
    rst = 1'b0;
    @(negedge refclk);
    rst = 1'b1;
    model_reset();
    repeat (20) step();
    cfg_valid = 1'b1;
    cfg_sel   = 2'd1;
    cfg_div   = W'(7);
    step();
    cfg_valid = 1'b0;
    repeat (10) step();
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL pending_ready: got %b expected 0", cfg_ready);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({outclk, tick, locked} !== '0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL pending_reset: got out=%b tick=%b lock=%b rdy=%b expected zeros rdy=1",
               outclk, tick, locked, cfg_ready);
    end
    @(negedge refclk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 870; i++) begin
      step();
      checks++;
      if ({outclk, tick, locked, cfg_ready} !== {exp_out, exp_tick, exp_locked, exp_ready}) begin
        errors++;
        $display("FAIL pending_restart edge %0d: got %b expected %b", edge_n,
                 {outclk, tick, locked, cfg_ready}, {exp_out, exp_tick, exp_locked, exp_ready});
      end
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL pending_final_ready: got %b expected 1", cfg_ready);
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_lock();
    test_default_run();
    test_async_reset();
`ifdef CLK_DIV_GEN_CFG_EN
    test_cfg_ch0();
    test_cfg_zero_ch1();
    test_cfg_invalid();
    test_cfg_random();
    test_reset_pending();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 Parameter NUM_CLKS, default 2, number of output channels, legal range 1..4.
REQ-002 Parameter DIV_W, default 16, width of each channel divisor.
REQ-003 Parameter DIV0, default 2, reset divisor of channel 0 (50 MHz refclk -> 25 MHz).
REQ-004 Parameter DIV1, default 434, reset divisor of channel 1 (UART baud base); channels 2..3 reset to divisor 1.
REQ-005 Parameter LOCK_CYCLES, default 16, refclk cycles from settle to locked assertion.
REQ-006 refclk  in  1  sole clock, all logic rising-edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 cfg_valid  in  1  divisor update request.
REQ-009 cfg_ready  out  1  update can be accepted this cycle.
REQ-010 cfg_sel  in  2  target channel of update.
REQ-011 cfg_div  in  DIV_W  new divisor.
REQ-012 outclk  out  NUM_CLKS  registered divided clocks.
REQ-013 tick  out  NUM_CLKS  one-cycle pulse coinciding with each outclk rising edge.
REQ-014 locked  out  1  all channels running at committed divisors and settled.

Function
REQ-015 Each channel SHALL hold an active divisor D (value 0 treated as 1) and a counter cnt cycling 0..D-1.
REQ-016 Per edge: cnt==D-1 -> cnt<=0 and pending divisor (if any) becomes D; otherwise cnt<=cnt+1.
REQ-017 outclk[i] SHALL be registered as 1 when next cnt < ceil(D/2), else 0; odd D gives high phase one cycle longer.
REQ-018 tick[i] SHALL be registered as 1 exactly when next cnt==0.
REQ-019 D==1: outclk[i] constant 1 and tick[i] high every cycle while out of reset.
REQ-020 Handshake: update accepted on a cycle with cfg_valid && cfg_ready; cfg_sel/cfg_div captured into that channel's pending register.
REQ-021 cfg_ready SHALL be 0 from the cycle after acceptance until the pending divisor is committed, then return to 1.
REQ-022 A pending divisor SHALL commit only at the channel's next wrap; acceptance coinciding with a wrap commits at the following wrap, never the current one (glitch-free).
REQ-023 cfg_sel >= NUM_CLKS: request accepted, ignored, cfg_ready stays 1, locked unaffected.
REQ-024 Lock FSM states: SETTLE (lock counter 0..LOCK_CYCLES-1), LOCKED, PENDING.
REQ-025 SETTLE -> LOCKED when lock counter reaches LOCK_CYCLES-1; locked=1 only in LOCKED.
REQ-026 Valid-channel acceptance in SETTLE or LOCKED -> PENDING with locked=0 next cycle; PENDING -> SETTLE with counter 0 on commit.

Reset
REQ-027 rst low SHALL asynchronously force: cnt[i]=reset divisor-1, outclk=0, tick=0, locked=0, cfg_ready=1, no pending, FSM=SETTLE, lock counter 0.
REQ-028 First edge after rst release: all channels wrap together, so outclk=all-ones and tick=all-ones (phase-aligned start).
REQ-029 rst asserted mid-update SHALL discard the pending divisor; channel restarts at its parameter divisor.

Configuration
REQ-030 Macro CLK_DIV_GEN_CFG_EN defined: runtime update path (REQ-020..023, PENDING state) compiled in.
REQ-031 Macro undefined: cfg_ready tied 0, cfg_valid/cfg_sel/cfg_div ignored, divisors fixed at parameters, FSM only SETTLE/LOCKED.

Verification
REQ-032 Defaults, release rst -> outclk[0] toggles every cycle (25 MHz from 50 MHz), tick[0] every 2nd cycle, tick[1] every 434th, both ticks high on first edge.
REQ-033 Release rst -> locked rises exactly 16 edges after release, stays 1 with no cfg activity.
REQ-034 CFG_EN, ch0 at D=2, cfg_sel=0 cfg_div=5 -> locked and cfg_ready drop next cycle; after next ch0 wrap outclk[0] period 5 (3 high, 2 low); locked returns 16 cycles after commit.
REQ-035 cfg_div=0 on ch1 -> after commit outclk[1]=1 constant, tick[1] every cycle; cfg_sel=3 with NUM_CLKS=2 -> no output change, locked stays 1.
REQ-036 Assert rst while ch1 update pending -> all outputs zero immediately (async); after release ch1 runs at 434, cfg_ready=1.
REQ-037 Without CFG_EN: cfg_valid=1 with any data -> cfg_ready stays 0, outclk periods unchanged from parameters.
